// File: rtl/bloom_builder.sv
// Bloom filter writer/query engine: hashes a 5-letter word one letter per
// cycle with two multiplicative hashes, then sets or tests two filter bits.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_word
// command port; rsp_valid/rsp_ready/rsp_hit response port; filter (256-bit
// live filter); insert_count (saturating insert count since last clear).
// Macro BLOOM_BUILDER_COUNT_EN: when defined, insert_count is a real
// counter; otherwise it is tied to zero.
module bloom_builder #(
   parameter logic [39:0] HASH0_K = 40'hF4_F9_85_C5_E6,
   parameter logic [39:0] HASH1_K = 40'h77_DC_77_FA_B6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [24:0]  cmd_word,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_hit,
   output logic [255:0] filter,
   output logic [7:0]   insert_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HASH  = 2'd1,
      APPLY = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] OP_QUERY  = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   state_t       state;
   logic [1:0]   op_q;
   logic [24:0]  word_q;
   logic [2:0]   idx;
   logic [7:0]   acc0;
   logic [7:0]   acc1;
   logic [255:0] filter_q;
   logic         hit_q;
   logic         clr_cnt;
   logic         inc_cnt;

   logic [4:0]   letter;
   logic [7:0]   k0;
   logic [7:0]   k1;
   logic [7:0]   p0;
   logic [7:0]   p1;

   // Products are only needed mod 256, so 8-bit multiplies suffice.
   always_comb begin
      letter = 5'(word_q >> (5 * idx));
      k0     = 8'(HASH0_K >> (8 * idx));
      k1     = 8'(HASH1_K >> (8 * idx));
      p0     = {3'b000, letter} * k0;
      p1     = {3'b000, letter} * k1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= 2'b00;
         word_q   <= '0;
         idx      <= '0;
         acc0     <= '0;
         acc1     <= '0;
         filter_q <= '0;
         hit_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  word_q <= cmd_word;
                  idx    <= '0;
                  acc0   <= '0;
                  acc1   <= '0;
                  if (cmd_op == OP_QUERY || cmd_op == OP_INSERT) begin
                     state <= HASH;
                  end else begin
                     // Clear/no-op take one bookkeeping cycle in APPLY so
                     // the response appears one edge after acceptance.
                     hit_q <= 1'b0;
                     state <= APPLY;
                     if (cmd_op == OP_CLEAR) filter_q <= '0;
                  end
               end
            end
            HASH: begin
               acc0 <= acc0 + p0;
               acc1 <= acc1 + p1;
               idx  <= idx + 3'd1;
               if (idx == 3'd4) state <= APPLY;
            end
            APPLY: begin
               if (op_q == OP_QUERY || op_q == OP_INSERT) begin
                  hit_q <= filter_q[acc0] & filter_q[acc1];
               end
               if (op_q == OP_INSERT) begin
                  filter_q[acc0] <= 1'b1;
                  filter_q[acc1] <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign clr_cnt = (state == IDLE) && cmd_valid && (cmd_op == OP_CLEAR);
   assign inc_cnt = (state == APPLY) && (op_q == OP_INSERT);

`ifdef BLOOM_BUILDER_COUNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_cnt) begin
         cnt_q <= '0;
      end else if (inc_cnt && cnt_q != 8'hFF) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign insert_count = cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt   = clr_cnt ^ inc_cnt;
   assign insert_count = 8'd0;
`endif

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_hit   = hit_q;
   assign filter    = filter_q;

endmodule
